kws_inference_scheduler: RTL and testbench
==========================================

# kws_inference_scheduler

Sequences keyword-spotting inference between the feature extractor and the Tsetlin machine accelerator. Converts `fe_complete` into accelerator start pulses, drops frames that arrive while an inference is in flight, and guards each run with a watchdog. It smooths per-frame classifications with a sliding majority vote before driving the chip-level `Result`/`Inf_Done` pins. It sits in the `sys_clk` domain and is enabled by the SPI `SPI_EN_INF` register.

## Interface
Parameters:
- `N_CLASS`, 16: number of classes. Class index width `CW = $clog2(N_CLASS)`, which is 4 bits at the default.
- `VOTE_DEPTH`, 4: maximum vote window length, in results.
- `TO_WIDTH`, 16: width of the watchdog counter.

Ports:
- `sys_clk` in 1: system clock. All logic is rising-edge.
- `sys_rst_n` in 1: reset, **asynchronous, active-low**. This is the only clock and the only reset.
- `en_inf` in 1: level input, from `SPI_EN_INF`.
- `cfg_vote_len` in `$clog2(VOTE_DEPTH+1)`: vote window length. Value 0 is treated as 1; values above `VOTE_DEPTH` are clamped to `VOTE_DEPTH`.
- `cfg_timeout` in `TO_WIDTH`: watchdog limit in cycles. Value 0 disables the watchdog.
- `fe_complete` in 1: one-cycle pulse indicating the feature bank holds a new frame set.
- `acc_start` out 1: one-cycle pulse that starts the accelerator.
- `acc_done` in 1: one-cycle pulse; `acc_result` is valid in the same cycle.
- `acc_result` in CW: raw per-frame class.
- `Result` out CW: voted class, held until the next update.
- `Inf_Done` out 1: one-cycle pulse per voted result.
- `busy` out 1: high in RUN and VOTE.
- `overrun_cnt` out 8: count of dropped `fe_complete` pulses; saturates at 255.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
State machine states: IDLE, ARMED, RUN, VOTE. Reset enters IDLE.

- **IDLE**
  - `en_inf=1` moves to ARMED.
  - On that move, clear `overrun_cnt`, `timeout_err` and the vote history.
- **ARMED**
  - `fe_complete` moves to RUN and asserts `acc_start` for exactly one cycle.
  - Clear the watchdog counter on entry.
- **RUN**
  - The watchdog counter increments every cycle.
  - `acc_done`: push `acc_result` into the history, then move to VOTE.
  - Watchdog: when `cfg_timeout!=0` and the counter equals `cfg_timeout` with no `acc_done`, set `timeout_err`, return to ARMED, leave the history untouched and do not pulse `Inf_Done`.
  - If `acc_done` and timeout occur in the same cycle, `acc_done` wins.
- **VOTE** (one cycle)
  - Register the voted class into `Result` and pulse `Inf_Done`, then move to ARMED.
- **Global rule:** `en_inf=0` in any state moves to IDLE on the next edge.
  - Any pending `acc_done` is ignored.
  - `Result` holds its value.
  - The history is cleared on the next arm, not on disable.
- **Overrun:** `fe_complete` seen in RUN or VOTE increments `overrun_cnt`, saturating, and the frame is dropped. This includes the cycle where `acc_done` coincides.
- **Stray handshakes:** `acc_done` outside RUN is ignored. `fe_complete` in IDLE is ignored and not counted.
- **Vote computation:**
  - The history is a shift register of `VOTE_DEPTH` entries, each a class plus a valid bit.
  - The window is the newest `min(cfg_vote_len, valid entries)` entries.
  - Winner is the class with the highest count in the window.
  - Ties go to the most recent entry among the tied classes.
  - With window 1, `Result` equals the raw `acc_result`.
- **Config timing:** `cfg_vote_len` may change at any time and takes effect at the next VOTE. The history is not flushed.

## Timing
- **Reset values:** state IDLE, `acc_start=0`, `Result=0`, `Inf_Done=0`, `busy=0`, `overrun_cnt=0`, `timeout_err=0`, all history valid bits 0.
- **Start latency:** `fe_complete` sampled at edge t in ARMED gives `acc_start` high during t+1 and `busy` high from t+1.
- **Result latency:** `acc_done` sampled at edge t gives state VOTE during t+1; `Result` updates and `Inf_Done` is high during t+2.
  - The earliest next `acc_start` is t+3, following `fe_complete` at t+2.
- **Timeout latency:** `timeout_err` rises one cycle after the counter match and stays high until the next arm.
- **Outputs:** all outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `kws_sched_pkg`** holds:
  - the state enum `sched_state_t`;
  - `CW`;
  - the `vote_entry_t` struct (`logic valid`, `logic [CW-1:0] cls`);
  - the saturation constant 8'hFF.
- **Sub-module `kws_vote_unit`** holds the history shift register (push and clear inputs) and the combinational window majority with recency tie-break.
  - It produces the winning class.
  - The scheduler registers that class in VOTE.
- **Scheduler** keeps the FSM, watchdog, overrun counter and output registers.

## Test plan
- **Basic run:** `en_inf=1`, `cfg_vote_len=1`, `fe_complete`, then `acc_done` with `acc_result=7` three cycles later → one `acc_start` pulse; `Result=7` and `Inf_Done` exactly 2 cycles after `acc_done`.
- **Vote window and tie-break:** `cfg_vote_len=4`, raw results 3,5,3,5 → `Result` 3,5,3,5 (each tie resolved to the most recent entry); a fifth result 5 → `Result=5`; a sixth result 2 → `Result=5`.
- **Overrun:** two `fe_complete` pulses during RUN, plus one coincident with `acc_done` → `overrun_cnt=3` and no extra `acc_start`. After 300 overruns, `overrun_cnt=255`.
- **Watchdog:** `cfg_timeout=10` with no `acc_done` → `timeout_err=1`, no `Inf_Done`, state ARMED. Then `acc_done` and the timeout match in the same cycle → normal result and no new error. With `cfg_timeout=0` → no timeout after 70000 cycles.
- **Disable and reset mid-run:** drop `en_inf` in RUN, then send `acc_done` → ignored and `Result` unchanged; re-arm → counters and history cleared. Assert `sys_rst_n` low in VOTE → all outputs at reset values immediately.

Source files
------------

// File: rtl/kws_sched_pkg.sv
// Shared types and constants for the keyword-spotting inference scheduler.
package kws_sched_pkg;

    localparam int N_CLASS_DEF = 16;
    localparam int CW          = $clog2(N_CLASS_DEF);

    localparam logic [7:0] OVR_SAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        VOTE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] cls;
    } vote_entry_t;

endpackage

// File: rtl/kws_vote_unit.sv
// Result history shift register plus sliding-window majority vote.
// Ties resolve to the class whose latest occurrence is newest.
module kws_vote_unit
    import kws_sched_pkg::*;
#(
    parameter int VOTE_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               push,
    input  logic [CW-1:0]                      push_cls,
    input  logic [$clog2(VOTE_DEPTH+1)-1:0]    vote_len,
    output logic [CW-1:0]                      win_cls
);

    localparam int LW = $clog2(VOTE_DEPTH + 1);

    vote_entry_t           hist [VOTE_DEPTH];
    logic [LW-1:0]         win_len;
    logic [VOTE_DEPTH-1:0] in_win;
    logic [LW-1:0]         cnt;
    logic [LW-1:0]         best_cnt;

    // Entry 0 is the newest; valid entries are always contiguous from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOTE_DEPTH; i++) hist[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < VOTE_DEPTH; i++) hist[i].valid <= 1'b0;
        end else if (push) begin
            hist[0] <= '{valid: 1'b1, cls: push_cls};
            for (int i = 1; i < VOTE_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        win_len = vote_len;
        if (vote_len == '0) begin
            win_len = LW'(1);
        end else if (vote_len > LW'(VOTE_DEPTH)) begin
            win_len = LW'(VOTE_DEPTH);
        end
    end

    always_comb begin
        in_win = '0;
        for (int i = 0; i < VOTE_DEPTH; i++) begin
            in_win[i] = hist[i].valid && (LW'(i) < win_len);
        end
    end

    // Scanning newest-first with a strict compare keeps the most recent tied class.
    always_comb begin
        win_cls  = hist[0].cls;
        best_cnt = '0;
        cnt      = '0;
        for (int i = 0; i < VOTE_DEPTH; i++) begin
            cnt = '0;
            for (int j = 0; j < VOTE_DEPTH; j++) begin
                if (in_win[j] && (hist[j].cls == hist[i].cls)) cnt = cnt + LW'(1);
            end
            if (in_win[i] && (cnt > best_cnt)) begin
                best_cnt = cnt;
                win_cls  = hist[i].cls;
            end
        end
    end

endmodule

// File: rtl/kws_inference_scheduler.sv
// Turns feature-extractor completions into accelerator runs, guards each run
// with a watchdog and publishes majority-voted classes on Result/Inf_Done.
module kws_inference_scheduler
    import kws_sched_pkg::*;
#(
    parameter int N_CLASS    = 16,
    parameter int VOTE_DEPTH = 4,
    parameter int TO_WIDTH   = 16
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              en_inf,
    input  logic [$clog2(VOTE_DEPTH+1)-1:0]   cfg_vote_len,
    input  logic [TO_WIDTH-1:0]               cfg_timeout,
    input  logic                              fe_complete,
    output logic                              acc_start,
    input  logic                              acc_done,
    input  logic [$clog2(N_CLASS)-1:0]        acc_result,
    output logic [$clog2(N_CLASS)-1:0]        Result,
    output logic                              Inf_Done,
    output logic                              busy,
    output logic [7:0]                        overrun_cnt,
    output logic                              timeout_err,
    output sched_state_t                      dbg_state
);

    sched_state_t          state;
    logic [TO_WIDTH-1:0]   wd_cnt;
    logic                  hist_clear;
    logic                  hist_push;
    logic                  wd_hit;
    logic [CW-1:0]         win_cls;

    assign dbg_state  = state;
    assign hist_clear = (state == IDLE) && en_inf;
    assign hist_push  = (state == RUN) && en_inf && acc_done;
    assign wd_hit     = (cfg_timeout != '0) && (wd_cnt == cfg_timeout);

    kws_vote_unit #(
        .VOTE_DEPTH (VOTE_DEPTH)
    ) u_vote (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clear    (hist_clear),
        .push     (hist_push),
        .push_cls (acc_result),
        .vote_len (cfg_vote_len),
        .win_cls  (win_cls)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            acc_start   <= 1'b0;
            Result      <= '0;
            Inf_Done    <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            acc_start <= 1'b0;
            Inf_Done  <= 1'b0;

            // Frames arriving while a run is in flight are dropped and counted.
            if ((state == RUN || state == VOTE) && fe_complete && overrun_cnt != OVR_SAT) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            if (!en_inf) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= ARMED;
                        overrun_cnt <= '0;
                        timeout_err <= 1'b0;
                    end
                    ARMED: begin
                        wd_cnt <= '0;
                        if (fe_complete) begin
                            state     <= RUN;
                            acc_start <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    RUN: begin
                        wd_cnt <= wd_cnt + TO_WIDTH'(1);
                        // A completion in the match cycle beats the watchdog.
                        if (acc_done) begin
                            state <= VOTE;
                        end else if (wd_hit) begin
                            timeout_err <= 1'b1;
                            state       <= ARMED;
                            busy        <= 1'b0;
                        end
                    end
                    VOTE: begin
                        Result   <= win_cls;
                        Inf_Done <= 1'b1;
                        state    <= ARMED;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kws_inference_scheduler.sv
// Self-checking bench for kws_inference_scheduler with a vote scoreboard.
module tb_kws_inference_scheduler;
  import kws_sched_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         en_inf;
  logic [2:0]   cfg_vote_len;
  logic [15:0]  cfg_timeout;
  logic         fe_complete;
  logic         acc_start;
  logic         acc_done;
  logic [3:0]   acc_result;
  logic [3:0]   result;
  logic         inf_done;
  logic         busy;
  logic [7:0]   overrun_cnt;
  logic         timeout_err;
  sched_state_t dbg_state;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int start_mark;
  logic [3:0] exp_q[$];
  int hist_m[$];
  logic [3:0] last_exp = '0;

  kws_inference_scheduler dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .en_inf       (en_inf),
    .cfg_vote_len (cfg_vote_len),
    .cfg_timeout  (cfg_timeout),
    .fe_complete  (fe_complete),
    .acc_start    (acc_start),
    .acc_done     (acc_done),
    .acc_result   (acc_result),
    .Result       (result),
    .Inf_Done     (inf_done),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // reference vote: class-centric count over the newest window entries
  function automatic logic [3:0] model_vote(input int len);
    int n;
    int best_cnt;
    int best_pos;
    logic [3:0] best;
    n = (len == 0) ? 1 : ((len > 4) ? 4 : len);
    if (n > hist_m.size()) n = hist_m.size();
    best = '0;
    best_cnt = 0;
    best_pos = 99;
    for (int c = 0; c < 16; c++) begin
      int cnt;
      int pos;
      cnt = 0;
      pos = 99;
      for (int i = 0; i < n; i++) begin
        if (hist_m[i] == c) begin
          cnt++;
          if (pos == 99) pos = i;
        end
      end
      if (cnt > best_cnt || (cnt == best_cnt && cnt > 0 && pos < best_pos)) begin
        best = 4'(c);
        best_cnt = cnt;
        best_pos = pos;
      end
    end
    return best;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    en_inf = 1'b1;
    tick();
    hist_m.delete();
    check("arm_state", dbg_state, ARMED);
  endtask

  task automatic disarm();
    en_inf = 1'b0;
    tick();
  endtask

  task automatic pulse_fe();
    fe_complete = 1'b1;
    tick();
    fe_complete = 1'b0;
    check("acc_start", acc_start, 1);
    check("busy_start", busy, 1);
  endtask

  task automatic done(input logic [3:0] res, input bit accept, input bit with_fe);
    acc_result = res;
    acc_done = 1'b1;
    fe_complete = with_fe;
    if (accept) begin
      hist_m.push_front(res);
      if (hist_m.size() > 4) void'(hist_m.pop_back());
      last_exp = model_vote(cfg_vote_len);
      exp_q.push_back(last_exp);
    end
    tick();
    acc_done = 1'b0;
    fe_complete = 1'b0;
    acc_result = 4'($urandom_range(0, 15));
  endtask

  task automatic run_frame(input logic [3:0] res);
    pulse_fe();
    repeat (2) tick();
    done(res, 1'b1, 1'b0);
    check("vote_state", dbg_state, VOTE);
    check("inf_done_early", inf_done, 0);
    tick();
    check("inf_done", inf_done, 1);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && inf_done) begin
      if (exp_q.size() == 0) check("spurious_inf_done", 1, 0);
      else check("result", result, exp_q.pop_front());
    end
    if (rst_n && acc_start) n_start++;
  end

  initial begin
    logic [3:0] seq [6];
    seq = '{4'd3, 4'd5, 4'd3, 4'd5, 4'd5, 4'd2};
    rst_n = 1'b0;
    en_inf = 1'b0;
    cfg_vote_len = 3'd1;
    cfg_timeout = '0;
    fe_complete = 1'b0;
    acc_done = 1'b0;
    acc_result = '0;
    repeat (3) tick();
    check("rst_state", dbg_state, IDLE);
    check("rst_acc_start", acc_start, 0);
    check("rst_result", result, 0);
    check("rst_inf_done", inf_done, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // stray fe_complete in IDLE is neither started nor counted
    fe_complete = 1'b1;
    tick();
    fe_complete = 1'b0;
    check("idle_fe_state", dbg_state, IDLE);
    check("idle_fe_overrun", overrun_cnt, 0);

    // basic run, window 1
    arm();
    start_mark = n_start;
    run_frame(4'd7);
    check("basic_result", result, 7);
    check("basic_starts", n_start - start_mark, 1);

    // vote window and tie-break
    disarm();
    arm();
    cfg_vote_len = 3'd4;
    foreach (seq[i]) run_frame(seq[i]);
    check("vote_final", result, 5);
    cfg_vote_len = 3'd0;
    run_frame(4'd9);
    cfg_vote_len = 3'd7;
    run_frame(4'd2);

    // overrun counting incl. coincident completion
    disarm();
    arm();
    start_mark = n_start;
    pulse_fe();
    tick();
    fe_complete = 1'b1; tick(); fe_complete = 1'b0;
    tick();
    fe_complete = 1'b1; tick(); fe_complete = 1'b0;
    done(4'd4, 1'b1, 1'b1);
    repeat (2) tick();
    check("overrun_3", overrun_cnt, 3);
    check("overrun_starts", n_start - start_mark, 1);
    pulse_fe();
    repeat (300) begin
      fe_complete = 1'b1; tick(); fe_complete = 1'b0; tick();
    end
    check("overrun_sat", overrun_cnt, 255);
    done(4'd6, 1'b1, 1'b0);
    repeat (2) tick();

    // watchdog fires
    cfg_timeout = 16'd10;
    pulse_fe();
    repeat (10) tick();
    check("wd_before", timeout_err, 0);
    check("wd_before_state", dbg_state, RUN);
    tick();
    check("wd_err", timeout_err, 1);
    check("wd_state", dbg_state, ARMED);
    check("wd_busy", busy, 0);
    repeat (3) tick();
    disarm();
    arm();
    check("wd_cleared", timeout_err, 0);
    check("overrun_cleared", overrun_cnt, 0);

    // completion coincident with the watchdog match
    pulse_fe();
    repeat (10) tick();
    done(4'd8, 1'b1, 1'b0);
    check("wd_race_state", dbg_state, VOTE);
    tick();
    check("wd_race_done", inf_done, 1);
    check("wd_race_err", timeout_err, 0);

    // disabled watchdog
    cfg_timeout = '0;
    pulse_fe();
    repeat (70000) tick();
    check("wd_off_err", timeout_err, 0);
    check("wd_off_state", dbg_state, RUN);
    done(4'd1, 1'b1, 1'b0);
    repeat (2) tick();

    // disable mid-run
    cfg_vote_len = 3'd4;
    run_frame(4'd5);
    run_frame(4'd5);
    check("pre_dis_result", result, last_exp);
    pulse_fe();
    fe_complete = 1'b1; tick(); fe_complete = 1'b0;
    fe_complete = 1'b1; tick(); fe_complete = 1'b0;
    disarm();
    check("dis_state", dbg_state, IDLE);
    check("dis_busy", busy, 0);
    done(4'd9, 1'b0, 1'b0);
    repeat (3) tick();
    check("dis_result_held", result, last_exp);
    check("dis_overrun", overrun_cnt, 2);
    arm();
    check("rearm_overrun", overrun_cnt, 0);
    run_frame(4'd1);
    check("rearm_hist_clear", result, 1);

    // reset while in VOTE
    pulse_fe();
    tick();
    done(4'd4, 1'b0, 1'b0);
    check("pre_rst_state", dbg_state, VOTE);
    rst_n = 1'b0;
    #1;
    check("vrst_state", dbg_state, IDLE);
    check("vrst_result", result, 0);
    check("vrst_inf_done", inf_done, 0);
    check("vrst_busy", busy, 0);
    check("vrst_acc_start", acc_start, 0);
    check("vrst_overrun", overrun_cnt, 0);
    check("vrst_timeout", timeout_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
